// File: rtl/tap_slave_pkg.sv
// Shared types and constants for the serial register-access responder.
package tap_pkg;

   // Width of the command field that follows the start bit.
   localparam int TAP_CMD_W = 2;

   // Command field encoding.
   typedef enum logic [1:0] {
      CMD_NOP    = 2'b00,
      CMD_WRITE  = 2'b01,
      CMD_READ   = 2'b10,
      CMD_IDCODE = 2'b11
   } cmd_t;

   // Frame decoder states.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_STOP,
      ST_COMMIT,
      ST_TURN1,
      ST_TURN2,
      ST_SHOUT
   } state_t;

   // Larger of two widths; sizes the shared shift register.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tap_shreg.sv
// Shift register with parallel load, serial input and a reloadable
// down-counter that marks the last bit of each shifted field.
module tap_shreg #(
   parameter int W  = 16,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   input  logic          shift,
   input  logic          sin,
   input  logic          cnt_load,
   input  logic [CW-1:0] cnt_val,
   input  logic          cnt_en,
   output logic [W-1:0]  q,
   output logic          cnt_zero
);

   logic [CW-1:0] cnt;

   // Data path: parallel load wins over a left shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[W-2:0], sin};
      end
   end

   // Bit counter: reloaded on field entry, counts down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt_load) begin
         cnt <= cnt_val;
      end else if (cnt_en && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/tap_slave.sv
// Serial register-access responder: decodes start/stop framed commands
// on tdi and drives single-cycle register-bus writes and reads.
//
// Register bus: reg_we and reg_re are one-cycle strobes with no
// back-pressure. reg_addr/reg_wdata are valid in the reg_we cycle;
// reg_rdata must be valid in the cycle after reg_re.
module tap_slave
   import tap_pkg::*;
#(
   parameter int                ADDR_W = 8,
   parameter int                DATA_W = 16,
   parameter logic [DATA_W-1:0] IDCODE = 16'hA5C3
) (
   input  logic              tck,
   input  logic              trst,
   input  logic              tdi,
   output logic              tdo,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              err,
   output state_t            dbg_state
);

   localparam int SH_W  = max_int(ADDR_W, DATA_W);
   localparam int CNT_W = $clog2(SH_W + 1);

   state_t            state_q, state_d;
   cmd_t              cmd_q;
   logic              tdo_q, tdo_d;
   logic [ADDR_W-1:0] addr_q;
   logic              addr_cap;
   logic              err_q;

   logic              sh_load, sh_shift, cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0]  cnt_val;
   logic [SH_W-1:0]   sh_q, sh_load_val;

   tap_shreg #(
      .W  (SH_W),
      .CW (CNT_W)
   ) u_shreg (
      .clk      (tck),
      .rst      (trst),
      .load     (sh_load),
      .load_val (sh_load_val),
      .shift    (sh_shift),
      .sin      (tdi),
      .cnt_load (cnt_load),
      .cnt_val  (cnt_val),
      .cnt_en   (cnt_en),
      .q        (sh_q),
      .cnt_zero (cnt_zero)
   );

   // Next-state, shift-register control and next tdo value.
   always_comb begin
      state_d     = state_q;
      sh_load     = 1'b0;
      sh_shift    = 1'b0;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
      cnt_val     = '0;
      addr_cap    = 1'b0;
      tdo_d       = 1'b1;
      sh_load_val = (cmd_q == CMD_IDCODE) ? SH_W'(IDCODE) : SH_W'(reg_rdata);
      unique case (state_q)
         ST_IDLE: begin
            if (!tdi) begin
               state_d  = ST_CMD;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(TAP_CMD_W - 1);
            end
         end
         ST_CMD: begin
            if (cnt_zero) begin
               state_d  = ST_ADDR;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(ADDR_W - 1);
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_ADDR: begin
            sh_shift = 1'b1;
            if (cnt_zero) begin
               unique case (cmd_q)
                  CMD_WRITE: begin
                     state_d  = ST_WDATA;
                     addr_cap = 1'b1;
                     cnt_load = 1'b1;
                     cnt_val  = CNT_W'(DATA_W - 1);
                  end
                  CMD_READ: begin
                     state_d  = ST_TURN1;
                     addr_cap = 1'b1;
                  end
                  CMD_IDCODE: state_d = ST_TURN1;
                  default:    state_d = ST_IDLE;
               endcase
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_WDATA: begin
            sh_shift = 1'b1;
            if (cnt_zero) begin
               state_d = ST_STOP;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_STOP:   state_d = tdi ? ST_COMMIT : ST_IDLE;
         ST_COMMIT: state_d = ST_IDLE;
         ST_TURN1:  state_d = ST_TURN2;
         ST_TURN2: begin
            state_d  = ST_SHOUT;
            sh_load  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(DATA_W - 1);
            tdo_d    = sh_load_val[DATA_W-1];
         end
         ST_SHOUT: begin
            sh_shift = 1'b1;
            if (cnt_zero) begin
               state_d = ST_IDLE;
            end else begin
               cnt_en = 1'b1;
               tdo_d  = sh_q[DATA_W-2];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, command, address, tdo and sticky error registers.
   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         state_q <= ST_IDLE;
         cmd_q   <= CMD_NOP;
         tdo_q   <= 1'b1;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tdo_q   <= tdo_d;
         if (state_q == ST_CMD) begin
            cmd_q <= cmd_t'({cmd_q[0], tdi});
         end
         if (addr_cap) begin
            addr_q <= {sh_q[ADDR_W-2:0], tdi};
         end
         if ((state_q == ST_STOP) && !tdi) begin
            err_q <= 1'b1;
         end
      end
   end

   assign reg_we    = (state_q == ST_COMMIT);
   assign reg_re    = (state_q == ST_TURN1) && (cmd_q == CMD_READ);
   assign reg_wdata = reg_we ? sh_q[DATA_W-1:0] : '0;
   assign reg_addr  = addr_q;
   assign tdo       = tdo_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tap_slave.sv
// Directed and randomized frames against a behavioural register-file view.
module tb_tap_slave;
   import tap_pkg::*;

   localparam int          ADDR_W     = 8;
   localparam int          DATA_W     = 16;
   localparam logic [15:0] IDCODE_VAL = 16'hA5C3;
   localparam int          WE_FRAME_CYC = 1 + TAP_CMD_W + ADDR_W + DATA_W + 1 + 1;
   localparam int          RE_FRAME_CYC = 1 + TAP_CMD_W + ADDR_W + 1;

   logic              tck = 1'b0;
   logic              trst = 1'b1;
   logic              tdi = 1'b1;
   logic              tdo;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_we, reg_re, err;
   logic [DATA_W-1:0] reg_rdata = '0;
   state_t            dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int we_cnt = 0, re_cnt = 0, overlap = 0, we_cyc = 0, re_cyc = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] bus_mem [0:255] = '{16: 16'h1234, default: 16'h0000};

   tap_slave #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .IDCODE (IDCODE_VAL)
   ) dut (
      .tck       (tck),
      .trst      (trst),
      .tdi       (tdi),
      .tdo       (tdo),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // Clock and edge counter.
   always #5 tck = ~tck;
   always @(posedge tck) cyc <= cyc + 1;

   // Register-file bus model: read data is valid only in the cycle after reg_re.
   always @(posedge tck) begin
      if (reg_we) bus_mem[reg_addr] <= reg_wdata;
      reg_rdata <= reg_re ? bus_mem[reg_addr] : DATA_W'($urandom);
   end

   // Strobe monitor.
   always @(negedge tck) begin
      if (reg_we) begin we_cnt <= we_cnt + 1; we_cyc <= cyc; end
      if (reg_re) begin re_cnt <= re_cnt + 1; re_cyc <= cyc; end
      if (reg_we && reg_re) overlap <= overlap + 1;
   end

   task automatic tick();
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_header(input logic [1:0] cmd, input logic [7:0] addr, output int start_abs);
      tdi = 1'b0;
      tick();
      start_abs = cyc;
      for (int i = TAP_CMD_W - 1; i >= 0; i--) begin tdi = cmd[i]; tick(); end
      for (int i = ADDR_W - 1; i >= 0; i--) begin tdi = addr[i]; tick(); end
   endtask

   task automatic do_write(input string tag, input logic [7:0] addr, input logic [15:0] data,
                           input logic stop_bit);
      int s;
      int we0;
      we0 = we_cnt;
      send_header(2'b01, addr, s);
      for (int i = DATA_W - 1; i >= 0; i--) begin tdi = data[i]; tick(); end
      tdi = stop_bit;
      tick();
      if (stop_bit) begin
         check({tag, "_we"}, 32'(reg_we), 32'd1);
         check({tag, "_addr"}, 32'(reg_addr), 32'(addr));
         check({tag, "_wdata"}, 32'(reg_wdata), 32'(data));
         check({tag, "_we_cycle"}, 32'(we_cyc - s + 2), 32'(WE_FRAME_CYC));
      end else begin
         check({tag, "_no_we"}, 32'(reg_we), 32'd0);
         check({tag, "_err"}, 32'(err), 32'd1);
      end
      tdi = 1'b1;
      tick();
      check({tag, "_we_pulses"}, 32'(we_cnt - we0), stop_bit ? 32'd1 : 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [1:0] cmd, input logic [7:0] addr);
      int s;
      int re0;
      logic [15:0] rd;
      re0 = re_cnt;
      send_header(cmd, addr, s);
      if (cmd == 2'b10) begin
         check({tag, "_re"}, 32'(reg_re), 32'd1);
         check({tag, "_re_cycle"}, 32'(re_cyc - s + 2), 32'(RE_FRAME_CYC));
      end else begin
         check({tag, "_no_re"}, 32'(reg_re), 32'd0);
      end
      tdi = 1'($urandom); tick();
      tdi = 1'($urandom); tick();
      for (int i = DATA_W - 1; i >= 0; i--) begin
         rd[i] = tdo;
         tdi = 1'($urandom);
         tick();
      end
      tdi = 1'b1;
      check({tag, "_rdata"}, 32'(rd), 32'(exp_q.pop_front()));
      check({tag, "_tdo_idle"}, 32'(tdo), 32'd1);
      check({tag, "_re_pulses"}, 32'(re_cnt - re0), (cmd == 2'b10) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int s;
      int we0, re0;
      logic [7:0]  ra;
      logic [15:0] rdat;

      // Reset.
      repeat (3) @(negedge tck);
      trst = 1'b0;
      #1;
      check("rst_tdo", 32'(tdo), 32'd1);
      check("rst_we", 32'(reg_we), 32'd0);
      check("rst_re", 32'(reg_re), 32'd0);
      check("rst_addr", 32'(reg_addr), 32'd0);
      check("rst_wdata", 32'(reg_wdata), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // Directed write, read, idcode.
      do_write("wr_beef", 8'h3C, 16'hBEEF, 1'b1);
      check("wr_beef_err", 32'(err), 32'd0);
      exp_q.push_back(16'h1234);
      do_read("rd_1234", 2'b10, 8'h10);
      exp_q.push_back(IDCODE_VAL);
      do_read("idcode", 2'b11, 8'h5A);

      // Bad stop bit, then err stays set through a NOP frame.
      do_write("wr_badstop", 8'h22, 16'h0F0F, 1'b0);
      send_header(2'b00, 8'hFF, s);
      tdi = 1'b1;
      tick();
      check("nop_state", 32'(dbg_state), 32'(ST_IDLE));
      check("nop_err_sticky", 32'(err), 32'd1);

      // trst in the middle of write data.
      we0 = we_cnt;
      send_header(2'b01, 8'h77, s);
      for (int i = DATA_W - 1; i >= DATA_W - 8; i--) begin tdi = 1'($urandom); tick(); end
      tdi = 1'b1;
      trst = 1'b1;
      #1;
      trst = 1'b0;
      #1;
      check("trst_tdo", 32'(tdo), 32'd1);
      check("trst_we", 32'(reg_we), 32'd0);
      check("trst_re", 32'(reg_re), 32'd0);
      check("trst_addr", 32'(reg_addr), 32'd0);
      check("trst_wdata", 32'(reg_wdata), 32'd0);
      check("trst_err", 32'(err), 32'd0);
      repeat (DATA_W + 4) tick();
      check("trst_no_write", 32'(we_cnt - we0), 32'd0);
      do_write("wr_after_trst", 8'h77, 16'hC0DE, 1'b1);

      // Back-to-back write then read of the same address.
      do_write("b2b_wr", 8'h3C, 16'h5AA5, 1'b1);
      exp_q.push_back(16'h5AA5);
      do_read("b2b_rd", 2'b10, 8'h3C);

      // Randomized write/read pairs.
      for (int k = 0; k < 6; k++) begin
         ra   = 8'($urandom_range(0, 255));
         rdat = 16'($urandom);
         do_write("rnd_wr", ra, rdat, 1'b1);
         exp_q.push_back(rdat);
         do_read("rnd_rd", 2'b10, ra);
      end

      // Idle line produces no strobes.
      we0 = we_cnt;
      re0 = re_cnt;
      tdi = 1'b1;
      repeat (100) tick();
      check("idle_we", 32'(we_cnt - we0), 32'd0);
      check("idle_re", 32'(re_cnt - re0), 32'd0);
      check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
      check("idle_tdo", 32'(tdo), 32'd1);
      check("we_re_overlap", 32'(overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
